move_input_conditioner: RTL and testbench

- Upstream front end of the 2048 game FSM. Takes four raw, bouncy, asynchronous push-buttons and produces clean direction pulses up/down/left/right for the FSM.
- Guarantees: each pulse is one Clk wide; at most one direction is asserted per cycle; at most one pulse per physical press.
- Holds a single pending move while the game FSM reports busy, i.e. when it is not in its WAIT state.

---
 rtl/move_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 106 ++++++++++
 rtl/move_input_conditioner.sv | 115 +++++++++++
 tb/tb_move_input_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// ============================================================================
// Module  : move_pkg
// Brief   : Move codes and button FSM states shared by the input conditioner
//           and the game FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package move_pkg;

  localparam logic [1:0] MOVE_UP    = 2'd0;
  localparam logic [1:0] MOVE_DOWN  = 2'd1;
  localparam logic [1:0] MOVE_LEFT  = 2'd2;
  localparam logic [1:0] MOVE_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    BTN_IDLE       = 2'd0,
    BTN_PRESS_WAIT = 2'd1,
    BTN_HELD       = 2'd2,
    BTN_REL_WAIT   = 2'd3
  } btn_state_t;

  // Bit 0 = up ... bit 3 = right; lowest set bit wins.
  function automatic logic [1:0] priority_code(input logic [3:0] ev);
    logic [1:0] code;
    code = MOVE_RIGHT;
    if (ev[0])      code = MOVE_UP;
    else if (ev[1]) code = MOVE_DOWN;
    else if (ev[2]) code = MOVE_LEFT;
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchronizer plus debounce FSM for one push-button; emits a
//           one-cycle event per accepted press. Auto-repeat under
//           MOVE_AUTOREPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn,
  output logic evt
);
  import move_pkg::*;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_CYCLES < 1) || ((2 ** CNT_W) <= DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("btn_debounce: invalid DEBOUNCE_CYCLES / CNT_W / REPEAT_CYCLES");
  end

  logic [1:0]       sync_ff;
  logic             sync;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             press_evt;

  assign sync    = sync_ff[1];
  assign at_last = (cnt == DEB_LAST);

  // Decoded from registers only, so the top's registered pulse lands one
  // cycle after the qualifying sample.
  assign press_evt = (state == BTN_PRESS_WAIT) && sync && at_last;

`ifdef MOVE_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_evt;

  assign rep_evt = (state == BTN_HELD) && sync && (rep_cnt == REP_LAST);
  assign evt     = press_evt | rep_evt;
`else
  assign evt = press_evt;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_ff <= 2'b00;
      state   <= BTN_REL_WAIT;
      cnt     <= '0;
`ifdef MOVE_AUTOREPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      sync_ff <= {sync_ff[0], btn};

      case (state)
        BTN_IDLE: begin
          if (sync) begin
            state <= BTN_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        BTN_PRESS_WAIT: begin
          if (!sync)        state <= BTN_IDLE;
          else if (at_last) state <= BTN_HELD;
          else              cnt   <= cnt + 1'b1;
        end
        BTN_HELD: begin
          if (!sync) begin
            state <= BTN_REL_WAIT;
            cnt   <= '0;
          end
        end
        BTN_REL_WAIT: begin
          if (sync)         cnt   <= '0;
          else if (at_last) state <= BTN_IDLE;
          else              cnt   <= cnt + 1'b1;
        end
        default: begin
          state <= BTN_REL_WAIT;
          cnt   <= '0;
        end
      endcase

`ifdef MOVE_AUTOREPEAT_EN
      if ((state == BTN_HELD) && sync)
        rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
      else
        rep_cnt <= '0;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_input_conditioner.sv
// ============================================================================
// Module  : move_input_conditioner
// Brief   : Debounces four direction buttons, arbitrates simultaneous presses
//           and holds one pending move while the game FSM is busy.
//           Optional auto-repeat: define MOVE_AUTOREPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       busy,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] move_code,
  output logic       move_dropped
);
  import move_pkg::*;

  logic [3:0] btn_raw;
  logic [3:0] evt;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_debounce (
      .Clk  (Clk),
      .Reset(Reset),
      .btn  (btn_raw[i]),
      .evt  (evt[i])
    );
  end

  logic       win_any;
  logic [1:0] win_code;
  logic       multi_evt;

  assign win_any   = |evt;
  assign win_code  = priority_code(evt);
  assign multi_evt = |(evt & (evt - 4'd1));

  logic       pend_valid;
  logic [1:0] pend_code;
  logic       pend_valid_d;
  logic [1:0] pend_code_d;
  logic       emit_now;
  logic [1:0] emit_code;
  logic       overflow;

  always_comb begin
    emit_now     = 1'b0;
    emit_code    = MOVE_UP;
    pend_valid_d = pend_valid;
    pend_code_d  = pend_code;
    overflow     = 1'b0;

    if (pend_valid && !busy) begin
      // Emitting the stored move frees the slot for a same-cycle winner.
      emit_now     = 1'b1;
      emit_code    = pend_code;
      pend_valid_d = win_any;
      if (win_any) pend_code_d = win_code;
    end else if (win_any) begin
      if (!busy && !pend_valid) begin
        emit_now  = 1'b1;
        emit_code = win_code;
      end else if (!pend_valid) begin
        pend_valid_d = 1'b1;
        pend_code_d  = win_code;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      up           <= 1'b0;
      down         <= 1'b0;
      left         <= 1'b0;
      right        <= 1'b0;
      move_code    <= 2'd0;
      move_dropped <= 1'b0;
      pend_valid   <= 1'b0;
      pend_code    <= 2'd0;
    end else begin
      up           <= emit_now && (emit_code == MOVE_UP);
      down         <= emit_now && (emit_code == MOVE_DOWN);
      left         <= emit_now && (emit_code == MOVE_LEFT);
      right        <= emit_now && (emit_code == MOVE_RIGHT);
      move_code    <= emit_now ? emit_code : 2'd0;
      move_dropped <= multi_evt | overflow;
      pend_valid   <= pend_valid_d;
      pend_code    <= pend_code_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
// ============================================================================
// Module  : tb_move_input_conditioner
// Brief   : Scoreboard bench: directed scenarios plus random bouncy buttons,
//           checked against a behavioural press/arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_input_conditioner;

  localparam int D = 4;
  localparam int R = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       busy = 1'b0;
  logic       up, down, left, right, move_dropped;
  logic [1:0] move_code;

  always #5 clk = ~clk;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .REPEAT_CYCLES  (R)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .btn_up      (btn[0]),
    .btn_down    (btn[1]),
    .btn_left    (btn[2]),
    .btn_right   (btn[3]),
    .busy        (busy),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .move_code   (move_code),
    .move_dropped(move_dropped)
  );

  typedef struct {
    int         cyc;
    logic [3:0] dirs;
    logic [1:0] code;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: a button must first see D consecutive low samples (after reset or
  // after a release), then D+1 consecutive high samples count as one press.
  int         mode [4];   // 0 = awaiting release, 1 = ready, 2 = held
  int         run  [4];
  logic [3:0] s1 = 4'b0;
  logic [3:0] s2 = 4'b0;
  bit         pend_v;
  int         pend_c;
`ifdef MOVE_AUTOREPEAT_EN
  int         hcnt [4];
`endif

  always @(posedge clk) begin : model
    logic [3:0] ev;
    int         win;
    int         outc;
    logic       drop;
    exp_t       e;
    cyc++;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        mode[b] = 0;
        run[b]  = 0;
`ifdef MOVE_AUTOREPEAT_EN
        hcnt[b] = 0;
`endif
      end
      s1 = 4'b0; s2 = 4'b0; pend_v = 0; pend_c = 0;
    end else begin
      ev = 4'b0;
      for (int b = 0; b < 4; b++) begin
        if (mode[b] == 0) begin
          if (s2[b]) run[b] = 0;
          else begin
            run[b]++;
            if (run[b] == D) begin mode[b] = 1; run[b] = 0; end
          end
        end else if (mode[b] == 1) begin
          if (s2[b]) begin
            run[b]++;
            if (run[b] == D + 1) begin
              ev[b] = 1'b1; mode[b] = 2;
`ifdef MOVE_AUTOREPEAT_EN
              hcnt[b] = 0;
`endif
            end
          end else run[b] = 0;
        end else begin
          if (!s2[b]) begin mode[b] = 0; run[b] = 0; end
`ifdef MOVE_AUTOREPEAT_EN
          else begin
            hcnt[b]++;
            if (hcnt[b] % R == 0) ev[b] = 1'b1;
          end
`endif
        end
      end
      s2 = s1;
      s1 = btn;

      win = -1;
      for (int b = 3; b >= 0; b--) if (ev[b]) win = b;
      drop = ($countones(ev) > 1);
      outc = -1;
      if (pend_v && !busy) begin
        outc   = pend_c;
        pend_v = (win >= 0);
        if (win >= 0) pend_c = win;
      end else if (win >= 0) begin
        if (!busy && !pend_v)   outc = win;
        else if (!pend_v) begin pend_v = 1; pend_c = win; end
        else                    drop = 1'b1;
      end
      if (outc >= 0 || drop) begin
        e.cyc  = cyc;
        e.dirs = (outc >= 0) ? (4'b0001 << outc) : 4'b0000;
        e.code = (outc >= 0) ? 2'(outc) : 2'd0;
        e.drop = drop;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [3:0] obs;
    exp_t       e;
    if (!rst) begin
      obs = {right, left, down, up};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_output cyc=%0d: got nothing, expected dirs=%b code=%0d drop=%b",
                 e.cyc, e.dirs, e.code, e.drop);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.dirs || move_code !== e.code || move_dropped !== e.drop) begin
          n_bad++;
          $display("FAIL output cyc=%0d: got dirs=%b code=%0d drop=%b, expected dirs=%b code=%0d drop=%b",
                   cyc, obs, move_code, move_dropped, e.dirs, e.code, e.drop);
        end
      end else if (obs != 4'b0 || move_code != 2'd0 || move_dropped) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output cyc=%0d: got dirs=%b code=%0d drop=%b, expected none",
                 cyc, obs, move_code, move_dropped);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({up, down, left, right, move_code, move_dropped} !== 7'b0) begin
      n_bad++;
      $display("FAIL %s: got outputs=%b, expected 0000000", tag,
               {up, down, left, right, move_code, move_dropped});
    end
  endtask

  initial begin
    int rate;
    // Reset and quiet period
    rst = 1'b1; tick(3);
    check_reset_outputs("reset_state");
    rst = 1'b0; tick(8);

    // Single left press held long
    btn = 4'b0100; tick(56);
    btn = 4'b0000; tick(10);

    // Bouncing up press
    btn = 4'b0001; tick(1);
    btn = 4'b0000; tick(1);
    btn = 4'b0001; tick(2);
    btn = 4'b0000; tick(1);
    btn = 4'b0001; tick(10);
    btn = 4'b0000; tick(10);

    // Down and right qualify together
    btn = 4'b1010; tick(12);
    btn = 4'b0000; tick(10);

    // Right pending while busy, left dropped, then busy released
    busy = 1'b1;
    btn = 4'b1000; tick(8);
    btn = 4'b1100; tick(8);
    busy = 1'b0; tick(4);
    btn = 4'b0000; tick(10);

    // Up held through reset must not fire until released
    btn = 4'b0001; tick(4);
    rst = 1'b1; tick(3);
    check_reset_outputs("reset_mid_press");
    rst = 1'b0; tick(8);
    btn = 4'b0000; tick(5);
    btn = 4'b0001; tick(10);
    btn = 4'b0000; tick(10);

    // Long down hold (exercises auto-repeat when enabled)
    btn = 4'b0010; tick(40);
    btn = 4'b0000; tick(10);

    // Random bouncy buttons and busy
    for (int i = 0; i < 1600; i++) begin
      if (i % 100 == 0) rate = $urandom_range(12, 3);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(rate - 1, 0) == 0) btn[b] = ~btn[b];
      if ($urandom_range(7, 0) == 0) busy = ~busy;
      if (i == 700 || i == 1300) begin
        rst = 1'b1; tick(2);
        check_reset_outputs("reset_random");
        rst = 1'b0;
      end
      tick(1);
    end

    btn = 4'b0000; busy = 1'b0; tick(20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding expected outputs, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
